// File: rtl/clk_switch_mon.sv
// Frequency monitor for the glitch-free clock switch output: counts mon_clk edges per window,
// classifies them as source A/B/stuck and flags disagreement with sel. Sticky flags: CLK_SWITCH_MON_STICKY_ERR_EN.
module clk_switch_mon #(
  parameter int WIN    = 1000,
  parameter int CNT_W  = 10,
  parameter int EXP_A  = 50,
  parameter int EXP_B  = 185,
  parameter int TOL    = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mon_clk,
  input  logic             sel,
  input  logic             err_clr,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             cnt_vld,
  output logic             src_a,
  output logic             src_b,
  output logic             stuck,
  output logic             mismatch,
  output logic             busy
);

  localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CW1   = CNT_W + 1;
  localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(WIN - 1);
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic signed [CNT_W:0]   EXP_A_S  = CW1'(EXP_A);
  localparam logic signed [CNT_W:0]   EXP_B_S  = CW1'(EXP_B);
  localparam logic signed [CNT_W:0]   TOL_S    = CW1'(TOL);

  typedef enum logic {ST_SETTLE, ST_MEAS} state_t;

  state_t             state_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [CNT_W-1:0]   edge_cnt_q;
  logic [SET_W-1:0]   settle_q;
  logic               mon_s1_q, mon_s2_q, mon_s3_q;
  logic               sel_s1_q, sel_s2_q, sel_s3_q;

  logic               mon_rise, sel_chg, win_close, settle_done, mm_now, in_a, in_b;
  logic [CNT_W-1:0]   edge_cnt_d;
  logic signed [CNT_W:0] diff_a, diff_b;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      {mon_s1_q, mon_s2_q, mon_s3_q} <= 3'b000;
      {sel_s1_q, sel_s2_q, sel_s3_q} <= 3'b000;
    end else begin
      {mon_s1_q, mon_s2_q, mon_s3_q} <= {mon_clk, mon_s1_q, mon_s2_q};
      {sel_s1_q, sel_s2_q, sel_s3_q} <= {sel, sel_s1_q, sel_s2_q};
    end
  end

  assign mon_rise    = mon_s2_q & ~mon_s3_q;
  assign sel_chg     = sel_s2_q ^ sel_s3_q;
  assign win_close   = (win_cnt_q == WIN_LAST);
  assign settle_done = (SETTLE <= 1) || (settle_q == SET_W'(SETTLE - 1));

  // Saturating sum includes an edge seen in the close cycle, so it belongs to the closing window.
  assign edge_cnt_d = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + CNT_W'(mon_rise);

  // Signed bounds check avoids an absolute value that could overflow CNT_W+1 bits.
  assign diff_a = $signed({1'b0, edge_cnt_d}) - EXP_A_S;
  assign diff_b = $signed({1'b0, edge_cnt_d}) - EXP_B_S;
  assign in_a   = (diff_a >= -TOL_S) && (diff_a <= TOL_S);
  assign in_b   = (diff_b >= -TOL_S) && (diff_b <= TOL_S);
  assign mm_now = sel_s2_q ? ~in_b : ~in_a;

`ifndef CLK_SWITCH_MON_STICKY_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_SETTLE;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      settle_q   <= '0;
      meas_cnt   <= '0;
      cnt_vld    <= 1'b0;
      src_a      <= 1'b0;
      src_b      <= 1'b0;
      stuck      <= 1'b0;
      mismatch   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      cnt_vld <= 1'b0;
`ifdef CLK_SWITCH_MON_STICKY_ERR_EN
      if (err_clr) begin
        stuck    <= 1'b0;
        mismatch <= 1'b0;
      end
`endif
      if (sel_chg) begin
        // Partial window (even a closing one) is dropped and settling starts over.
        state_q    <= ST_SETTLE;
        busy       <= 1'b1;
        settle_q   <= '0;
        win_cnt_q  <= '0;
        edge_cnt_q <= '0;
      end else if (win_close) begin
        win_cnt_q  <= '0;
        edge_cnt_q <= '0;
        if (state_q == ST_SETTLE) begin
          if (settle_done) begin
            state_q  <= ST_MEAS;
            busy     <= 1'b0;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end else begin
          meas_cnt <= edge_cnt_d;
          cnt_vld  <= 1'b1;
          src_a    <= in_a;
          src_b    <= in_b;
`ifdef CLK_SWITCH_MON_STICKY_ERR_EN
          if (edge_cnt_d == '0) stuck <= 1'b1;
          if (mm_now) mismatch <= 1'b1;
`else
          stuck    <= (edge_cnt_d == '0);
          mismatch <= mm_now;
`endif
        end
      end else begin
        win_cnt_q  <= win_cnt_q + 1'b1;
        edge_cnt_q <= edge_cnt_d;
      end
    end
  end

endmodule
